// File: rtl/xentry_dcache.sv
// Direct-mapped, write-back, write-allocate L1 data cache with a one-word-per-transfer L2 port.

package xentry_pkg;
    typedef enum logic {
        LOAD  = 1'b0,
        STORE = 1'b1
    } memory_operation_e;

    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } memory_operation_size_e;
endpackage

module xentry_dcache
    import xentry_pkg::*;
#(
    parameter int unsigned LINE_SIZE  = 16,
    parameter int unsigned CACHE_SIZE = 256,
    parameter int unsigned XLEN       = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [XLEN-1:0]        pipe_req_address,
    input  memory_operation_size_e pipe_req_size,
    input  memory_operation_e      pipe_req_type,
    input  logic                   pipe_req_valid,
    input  logic [XLEN-1:0]        pipe_word_to_store,
    output logic [XLEN-1:0]        pipe_fetched_word,
    output logic                   pipe_fetched_word_valid,
    output logic [XLEN-1:0]        l2_req_address,
    output memory_operation_e      l2_req_type,
    output logic                   l2_req_valid,
    output logic [XLEN-1:0]        l2_word_to_store,
    input  logic [XLEN-1:0]        l2_fetched_word,
    input  logic                   l2_fetched_word_valid
);

    localparam int unsigned WPL    = LINE_SIZE / 4;
    localparam int unsigned NLINES = CACHE_SIZE / LINE_SIZE;
    localparam int unsigned OFF_W  = $clog2(LINE_SIZE);
    localparam int unsigned IDX_W  = $clog2(NLINES);
    localparam int unsigned TAG_W  = XLEN - OFF_W - IDX_W;
    localparam int unsigned CNT_W  = (WPL > 1) ? $clog2(WPL) : 1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        FILL      = 2'd2
    } state_e;

    // Controller state
    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [IDX_W-1:0]   miss_index_q;
    logic [TAG_W-1:0]   miss_tag_q;
    logic [NLINES-1:0]  valid_q;
    logic [NLINES-1:0]  dirty_q;

    // Storage arrays (not reset; guarded by valid_q)
    logic [TAG_W-1:0]   tag_q  [NLINES];
    logic [XLEN-1:0]    data_q [NLINES][WPL];

    // Request decode
    logic [IDX_W-1:0]   req_index;
    logic [TAG_W-1:0]   req_tag;
    logic [CNT_W-1:0]   req_wsel;
    logic [1:0]         load_lane;
    logic               line_hit;
    logic               hit;
    logic               store_hit;
    logic               victim_dirty;
    logic [XLEN-1:0]    hit_word;
    logic [XLEN-1:0]    shifted_word;
    logic [XLEN-1:0]    store_rep;
    logic [3:0]         store_be;
    logic [XLEN-1:0]    merged_word;
    logic               fill_last;
    logic               cnt_last;

    // Line base address builder for L2 transfers
    function automatic logic [XLEN-1:0] line_addr(input logic [TAG_W-1:0] t,
                                                  input logic [IDX_W-1:0] i,
                                                  input logic [CNT_W-1:0] w);
        return (XLEN'(t) << (OFF_W + IDX_W)) | (XLEN'(i) << OFF_W) | (XLEN'(w) << 2);
    endfunction

    assign req_index = pipe_req_address[OFF_W +: IDX_W];
    assign req_tag   = pipe_req_address[XLEN-1 -: TAG_W];
    assign req_wsel  = CNT_W'(pipe_req_address >> 2) & CNT_W'(WPL - 1);
    assign cnt_last  = (cnt_q == CNT_W'(WPL - 1));
    assign fill_last = (state_q == FILL) && l2_fetched_word_valid && cnt_last;

    // Lookup, load alignment and store byte merge
    always_comb begin
        line_hit     = valid_q[req_index] && (tag_q[req_index] == req_tag);
        hit          = (state_q == IDLE) && pipe_req_valid && line_hit;
        store_hit    = hit && (pipe_req_type == STORE);
        victim_dirty = valid_q[req_index] && dirty_q[req_index];
        hit_word     = data_q[req_index][req_wsel];

        load_lane = 2'b00;
        case (pipe_req_size)
            BYTE:    load_lane = pipe_req_address[1:0];
            HALF:    load_lane = {pipe_req_address[1], 1'b0};
            default: load_lane = 2'b00;
        endcase
        shifted_word = hit_word >> {load_lane, 3'b000};

        pipe_fetched_word       = '0;
        pipe_fetched_word_valid = hit;
        if (hit) begin
            case (pipe_req_size)
                BYTE:    pipe_fetched_word = XLEN'(shifted_word[7:0]);
                HALF:    pipe_fetched_word = XLEN'(shifted_word[15:0]);
                default: pipe_fetched_word = shifted_word;
            endcase
        end

        store_be  = 4'b1111;
        store_rep = pipe_word_to_store;
        case (pipe_req_size)
            BYTE: begin
                store_be  = 4'b0001 << pipe_req_address[1:0];
                store_rep = XLEN'({4{pipe_word_to_store[7:0]}});
            end
            HALF: begin
                store_be  = pipe_req_address[1] ? 4'b1100 : 4'b0011;
                store_rep = XLEN'({2{pipe_word_to_store[15:0]}});
            end
            default: begin
                store_be  = 4'b1111;
                store_rep = pipe_word_to_store;
            end
        endcase

        merged_word = hit_word;
        for (int b = 0; b < 4; b++) begin
            if (store_be[b]) begin
                merged_word[8*b +: 8] = store_rep[8*b +: 8];
            end
        end
    end

    // L2 request drive, decoded from the controller state
    always_comb begin
        l2_req_valid     = 1'b0;
        l2_req_type      = LOAD;
        l2_req_address   = '0;
        l2_word_to_store = '0;
        case (state_q)
            WRITEBACK: begin
                l2_req_valid     = 1'b1;
                l2_req_type      = STORE;
                l2_req_address   = line_addr(tag_q[miss_index_q], miss_index_q, cnt_q);
                l2_word_to_store = data_q[miss_index_q][cnt_q];
            end
            FILL: begin
                l2_req_valid   = 1'b1;
                l2_req_type    = LOAD;
                l2_req_address = line_addr(miss_tag_q, miss_index_q, cnt_q);
            end
            default: begin
                l2_req_valid = 1'b0;
            end
        endcase
    end

    // Miss sequencer plus valid/dirty bookkeeping
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            miss_index_q <= '0;
            miss_tag_q   <= '0;
            valid_q      <= '0;
            dirty_q      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (store_hit) begin
                        dirty_q[req_index] <= 1'b1;
                    end
                    if (pipe_req_valid && !line_hit) begin
                        miss_index_q <= req_index;
                        miss_tag_q   <= req_tag;
                        cnt_q        <= '0;
                        state_q      <= victim_dirty ? WRITEBACK : FILL;
                    end
                end
                WRITEBACK: begin
                    if (cnt_last) begin
                        dirty_q[miss_index_q] <= 1'b0;
                        cnt_q                 <= '0;
                        state_q               <= FILL;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                FILL: begin
                    if (l2_fetched_word_valid) begin
                        if (cnt_last) begin
                            valid_q[miss_index_q] <= 1'b1;
                            dirty_q[miss_index_q] <= 1'b0;
                            cnt_q                 <= '0;
                            state_q               <= IDLE;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Data and tag array writes: store hits and incoming fill words
    always_ff @(posedge clk) begin
        if (store_hit) begin
            data_q[req_index][req_wsel] <= merged_word;
        end
        if ((state_q == FILL) && l2_fetched_word_valid) begin
            data_q[miss_index_q][cnt_q] <= l2_fetched_word;
        end
        if (fill_last) begin
            tag_q[miss_index_q] <= miss_tag_q;
        end
    end

endmodule

// File: tb/tb_xentry_dcache.sv
// Self-checking bench for xentry_dcache: directed scenarios plus a randomized soak
// against a flat architectural memory model.

module tb_xentry_dcache;
    import xentry_pkg::*;

    logic                   clk = 1'b0;
    logic                   reset = 1'b0;
    logic [31:0]            pipe_req_address = '0;
    memory_operation_size_e pipe_req_size = WORD;
    memory_operation_e      pipe_req_type = LOAD;
    logic                   pipe_req_valid = 1'b0;
    logic [31:0]            pipe_word_to_store = '0;
    logic [31:0]            pipe_fetched_word;
    logic                   pipe_fetched_word_valid;
    logic [31:0]            l2_req_address;
    memory_operation_e      l2_req_type;
    logic                   l2_req_valid;
    logic [31:0]            l2_word_to_store;
    logic [31:0]            l2_fetched_word = '0;
    logic                   l2_fetched_word_valid = 1'b0;

    xentry_dcache #(.LINE_SIZE(16), .CACHE_SIZE(256), .XLEN(32)) dut (
        .clk                     (clk),
        .reset                   (reset),
        .pipe_req_address        (pipe_req_address),
        .pipe_req_size           (pipe_req_size),
        .pipe_req_type           (pipe_req_type),
        .pipe_req_valid          (pipe_req_valid),
        .pipe_word_to_store      (pipe_word_to_store),
        .pipe_fetched_word       (pipe_fetched_word),
        .pipe_fetched_word_valid (pipe_fetched_word_valid),
        .l2_req_address          (l2_req_address),
        .l2_req_type             (l2_req_type),
        .l2_req_valid            (l2_req_valid),
        .l2_word_to_store        (l2_word_to_store),
        .l2_fetched_word         (l2_fetched_word),
        .l2_fetched_word_valid   (l2_fetched_word_valid)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int wait_pct = 0;
    int l2_cycles = 0;

    logic [31:0] l2_mem  [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] fill_q[$];
    logic [31:0] wb_a_q[$];
    logic [31:0] wb_d_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] init_word(input logic [31:0] wa);
        return (wa * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    function automatic logic [31:0] l2_rd(input logic [31:0] a);
        logic [31:0] k;
        k = a >> 2;
        if (l2_mem.exists(k)) return l2_mem[k];
        return init_word(k);
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        logic [31:0] k;
        k = a >> 2;
        if (ref_mem.exists(k)) return ref_mem[k];
        return init_word(k);
    endfunction

    // Architectural load: word shifted by its byte lane and masked to the access size
    function automatic logic [31:0] ref_load(input logic [31:0] a, input memory_operation_size_e sz);
        logic [31:0] w;
        logic [31:0] r;
        int lane;
        w = ref_rd(a);
        case (sz)
            BYTE:    lane = int'(a[1:0]);
            HALF:    lane = a[1] ? 2 : 0;
            default: lane = 0;
        endcase
        w = w >> (8 * lane);
        case (sz)
            BYTE:    r = w & 32'h0000_00FF;
            HALF:    r = w & 32'h0000_FFFF;
            default: r = w;
        endcase
        return r;
    endfunction

    task automatic ref_store(input logic [31:0] a, input memory_operation_size_e sz, input logic [31:0] d);
        logic [31:0] w;
        int lane;
        w = ref_rd(a);
        case (sz)
            BYTE: begin
                lane = int'(a[1:0]);
                w[8*lane +: 8] = d[7:0];
            end
            HALF: begin
                lane = a[1] ? 1 : 0;
                w[16*lane +: 16] = d[15:0];
            end
            default: w = d;
        endcase
        ref_mem[a >> 2] = w;
    endtask

    // L2 responder: word for the current request address, with random wait states
    always @(negedge clk) begin
        l2_fetched_word       = l2_rd(l2_req_address);
        l2_fetched_word_valid = ($urandom_range(99) >= wait_pct);
    end

    // L2 monitor: absorbs writebacks, logs accepted fills and writebacks
    always @(posedge clk) begin
        if (reset && l2_req_valid) begin
            l2_cycles++;
            if (l2_req_type == STORE) begin
                l2_mem[l2_req_address >> 2] = l2_word_to_store;
                wb_a_q.push_back(l2_req_address);
                wb_d_q.push_back(l2_word_to_store);
            end else if (l2_fetched_word_valid) begin
                fill_q.push_back(l2_req_address);
            end
        end
    end

    // One pipeline request, held until completion; lat counts cycles before completion
    task automatic do_req(input logic [31:0] a, input memory_operation_size_e sz,
                          input memory_operation_e ty, input logic [31:0] wd,
                          output logic [31:0] rd, output int lat);
        pipe_req_address   = a;
        pipe_req_size      = sz;
        pipe_req_type      = ty;
        pipe_word_to_store = wd;
        pipe_req_valid     = 1'b1;
        lat = 0;
        @(negedge clk);
        while (!pipe_fetched_word_valid && lat < 400) begin
            lat++;
            @(negedge clk);
        end
        check("req_done", 32'(pipe_fetched_word_valid), 32'd1);
        rd = pipe_fetched_word;
        @(posedge clk);
        #1;
        pipe_req_valid = 1'b0;
        if (ty == STORE) ref_store(a, sz, wd);
    endtask

    task automatic clear_logs();
        fill_q.delete();
        wb_a_q.delete();
        wb_d_q.delete();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] rd;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] exp;
        logic [31:0] w0;
        memory_operation_size_e sz;
        int lat;
        int snap;
        int n;

        l2_mem[32'h100 >> 2]  = 32'hDEAD_BEEF;
        ref_mem[32'h100 >> 2] = 32'hDEAD_BEEF;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_pipe_valid", 32'(pipe_fetched_word_valid), 32'd0);
        check("rst_pipe_word", pipe_fetched_word, 32'd0);
        check("rst_l2_valid", 32'(l2_req_valid), 32'd0);
        check("rst_l2_addr", l2_req_address, 32'd0);
        check("rst_l2_type", 32'(l2_req_type), 32'(LOAD));
        reset = 1'b1;
        @(posedge clk);
        #1;

        // 1: cold word load fills the whole line
        clear_logs();
        do_req(32'h100, WORD, LOAD, 32'h0, rd, lat);
        check("t1_data", rd, 32'hDEAD_BEEF);
        check("t1_latency", 32'(lat), 32'd5);
        check("t1_fill_count", 32'(fill_q.size()), 32'd4);
        if (fill_q.size() == 4) begin
            for (int i = 0; i < 4; i++) check("t1_fill_addr", fill_q[i], 32'h100 + 32'(4 * i));
        end

        // 2: hits with sub-word extraction, no L2 traffic
        snap = l2_cycles;
        do_req(32'h103, BYTE, LOAD, 32'h0, rd, lat);
        check("t2_byte", rd, 32'h0000_00DE);
        check("t2_byte_lat", 32'(lat), 32'd0);
        do_req(32'h102, HALF, LOAD, 32'h0, rd, lat);
        check("t2_half", rd, 32'h0000_DEAD);
        check("t2_no_l2", 32'(l2_cycles - snap), 32'd0);

        // 3: store miss allocates, then merges into the filled word
        do_req(32'h200, HALF, STORE, 32'h0000_BEEF, rd, lat);
        check("t3_store_lat", 32'(lat), 32'd5);
        w0 = init_word(32'h200 >> 2);
        do_req(32'h200, WORD, LOAD, 32'h0, rd, lat);
        check("t3_merged", rd, (w0 & 32'hFFFF_0000) | 32'h0000_BEEF);
        check("t3_hit_lat", 32'(lat), 32'd0);

        // 4: conflicting load evicts the dirty line first
        clear_logs();
        do_req(32'h300, WORD, LOAD, 32'h0, rd, lat);
        check("t4_data", rd, init_word(32'h300 >> 2));
        check("t4_latency", 32'(lat), 32'd9);
        check("t4_wb_count", 32'(wb_a_q.size()), 32'd4);
        if (wb_a_q.size() == 4) begin
            for (int i = 0; i < 4; i++) check("t4_wb_addr", wb_a_q[i], 32'h200 + 32'(4 * i));
            check("t4_wb_word0", wb_d_q[0] & 32'h0000_FFFF, 32'h0000_BEEF);
        end
        check("t4_fill_count", 32'(fill_q.size()), 32'd4);
        if (fill_q.size() == 4) begin
            for (int i = 0; i < 4; i++) check("t4_fill_addr", fill_q[i], 32'h300 + 32'(4 * i));
        end

        // 5: reset in the middle of a fill abandons it
        pipe_req_address = 32'h400;
        pipe_req_size    = WORD;
        pipe_req_type    = LOAD;
        pipe_req_valid   = 1'b1;
        n = 0;
        @(negedge clk);
        while (!l2_req_valid && n < 50) begin
            n++;
            @(negedge clk);
        end
        check("t5_fill_started", 32'(l2_req_valid), 32'd1);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("t5_l2_valid", 32'(l2_req_valid), 32'd0);
        check("t5_l2_addr", l2_req_address, 32'd0);
        check("t5_l2_type", 32'(l2_req_type), 32'(LOAD));
        check("t5_pipe_valid", 32'(pipe_fetched_word_valid), 32'd0);
        check("t5_pipe_word", pipe_fetched_word, 32'd0);
        pipe_req_valid = 1'b0;
        ref_mem.delete();
        foreach (l2_mem[k]) ref_mem[k] = l2_mem[k];
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        clear_logs();
        do_req(32'h400, WORD, LOAD, 32'h0, rd, lat);
        check("t5_refill_count", 32'(fill_q.size()), 32'd4);
        check("t5_refill_lat", 32'(lat), 32'd5);
        check("t5_data", rd, init_word(32'h400 >> 2));

        // 6: random soak with interleaved stores and L2 wait states
        wait_pct = 25;
        for (int i = 0; i < 2048; i++) begin
            if ($urandom_range(2) == 0) begin
                a  = 32'($urandom_range(32'h7FF));
                sz = memory_operation_size_e'(2'($urandom_range(2)));
                if (sz == HALF) a = a & ~32'h1;
                if (sz == WORD) a = a & ~32'h3;
                d  = $urandom;
                do_req(a, sz, STORE, d, rd, lat);
            end
            a  = 32'($urandom_range(32'h7FF));
            sz = memory_operation_size_e'(2'($urandom_range(2)));
            if (sz == HALF) a = a & ~32'h1;
            if (sz == WORD) a = a & ~32'h3;
            exp = ref_load(a, sz);
            do_req(a, sz, LOAD, 32'h0, rd, lat);
            check("soak_load", rd, exp);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
